// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter with start/data/odd-parity/stop framing,
// a post-stop error-listening window and bounded retransmission.
module uart_tx_frame #(
  parameter int WORD_LENGTH  = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int ACK_WAIT     = CLKS_PER_BIT,
  parameter int MAX_RETRY    = 1
) (
  input  logic                   t_clk,
  input  logic                   t_rst,
  input  logic [WORD_LENGTH-1:0] tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  input  logic                   err_ack,
  output logic                   UART_Tx_OUT,
  output logic                   tx_busy,
  output logic                   tx_done,
  output logic                   tx_fail
);

  localparam int CMAX = (CLKS_PER_BIT > ACK_WAIT) ?
                        CLKS_PER_BIT : ACK_WAIT;
  localparam int CW = $clog2(CMAX);
  localparam int BW = $clog2(WORD_LENGTH + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_ACKW   = 3'd5;

  logic [2:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [RW-1:0]          retry_q, retry_d;
  logic [WORD_LENGTH-1:0] shift_q, shift_d;
  logic [WORD_LENGTH-1:0] word_q, word_d;
  logic                   par_q, par_d;
  logic                   err_q, err_d;
  logic                   sync1_q, sync2_q;
  logic                   line_q, line_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   fail_q, fail_d;
  logic                   baud_end;

  assign baud_end = (cnt_q == CW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    retry_d = retry_q;
    shift_d = shift_q;
    word_d  = word_q;
    par_d   = par_q;
    err_d   = err_q;
    done_d  = 1'b0;
    fail_d  = 1'b0;
    if ((state_q == S_STOP || state_q == S_ACKW) && sync2_q)
      err_d = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (tx_valid && ready_q) begin
          shift_d = tx_data;
          word_d  = tx_data;
          par_d   = ~^tx_data;
          retry_d = '0;
          err_d   = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_d = cnt_q + CW'(1);
        if (baud_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        cnt_d = cnt_q + CW'(1);
        if (baud_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + BW'(1);
          if (bit_q == BW'(WORD_LENGTH - 1))
            state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        cnt_d = cnt_q + CW'(1);
        if (baud_end) begin
          cnt_d   = '0;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        cnt_d = cnt_q + CW'(1);
        if (baud_end) begin
          cnt_d   = '0;
          state_d = S_ACKW;
        end
      end
      S_ACKW: begin
        cnt_d = cnt_q + CW'(1);
        // A clean frame reports done in the last window cycle so that
        // back-to-back traffic sees exactly ACK_WAIT idle cycles.
        if (cnt_q == CW'(ACK_WAIT - 2) && !(err_q || sync2_q)) begin
          cnt_d   = '0;
          retry_d = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == CW'(ACK_WAIT - 1)) begin
          cnt_d = '0;
          err_d = 1'b0;
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + RW'(1);
            shift_d = word_q;
            state_d = S_START;
          end else begin
            retry_d = '0;
            fail_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    line_d = 1'b1;
    case (state_d)
      S_START:  line_d = 1'b0;
      S_DATA:   line_d = shift_d[0];
      S_PARITY: line_d = par_d;
      default:  line_d = 1'b1;
    endcase
  end

  assign ready_d = (state_d == S_IDLE);
  assign busy_d  = (state_d != S_IDLE);

  always_ff @(posedge t_clk) begin
    if (t_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      retry_q <= '0;
      shift_q <= '0;
      word_q  <= '0;
      par_q   <= 1'b0;
      err_q   <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      line_q  <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      retry_q <= retry_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      par_q   <= par_d;
      err_q   <= err_d;
      sync1_q <= err_ack;
      sync2_q <= sync1_q;
      line_q  <= line_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
    end
  end

  assign UART_Tx_OUT = line_q;
  assign tx_ready    = ready_q;
  assign tx_busy     = busy_q;
  assign tx_done     = done_q;
  assign tx_fail     = fail_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed table plus randomized words against a
// frame-level model of the transmitter.
module tb_uart_tx_frame;

  localparam int CPB   = 4;
  localparam int AW    = 4;
  localparam int MAXR  = 1;
  localparam int FRAME = 11 * CPB;
  localparam int STOP_FIRST = 10 * CPB + 1;
  localparam int STOP_LAST  = 11 * CPB;

  logic       t_clk = 1'b0;
  logic       t_rst;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       err_ack;
  logic       UART_Tx_OUT;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_fail;

  uart_tx_frame #(
    .WORD_LENGTH(8),
    .CLKS_PER_BIT(CPB),
    .ACK_WAIT(AW),
    .MAX_RETRY(MAXR)
  ) dut (
    .t_clk(t_clk),
    .t_rst(t_rst),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .err_ack(err_ack),
    .UART_Tx_OUT(UART_Tx_OUT),
    .tx_busy(tx_busy),
    .tx_done(tx_done),
    .tx_fail(tx_fail)
  );

  always #5 t_clk = ~t_clk;

  typedef struct {
    logic [7:0] data;
    logic [1:0] emask;
    int         es;
    int         el;
    bit         b2b;
    int         gap;
    int         exp_att;
    bit         exp_fail;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int tc = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s case=%0d cyc=%0d got=%0h exp=%0h",
               nm, tc, cyc, got, exp);
    end
  endtask

  // Line level k cycles (1-based) into a frame carrying d.
  function automatic logic frame_bit(input logic [7:0] d, input int k);
    int b;
    b = (k - 1) / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (b == 9) return ($countones(d) % 2) == 0;
    return 1'b1;
  endfunction

  function automatic bit err_hit(input vec_t v, input int a);
    return v.emask[a] && v.es <= STOP_LAST &&
           (v.es + v.el - 1) >= STOP_FIRST;
  endfunction

  function automatic vec_t predict(input vec_t v);
    vec_t r;
    r = v;
    r.exp_fail = 1'b0;
    r.exp_att = 1;
    for (int a = 0; a <= MAXR; a++) begin
      r.exp_att = a + 1;
      if (!err_hit(v, a)) break;
      if (a == MAXR) r.exp_fail = 1'b1;
    end
    return r;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge t_clk); #1;
      cyc = -1 - i;
      chk("idle_line", UART_Tx_OUT, 1);
      chk("idle_ready", tx_ready, 1);
      chk("idle_busy", tx_busy, 0);
      chk("idle_done", tx_done, 0);
      chk("idle_fail", tx_fail, 0);
    end
  endtask

  task automatic xfer(input vec_t v);
    bit fin_ok;
    chk("ready_pre", tx_ready, 1);
    tx_data  = v.data;
    tx_valid = 1'b1;
    for (int a = 0; a < v.exp_att; a++) begin
      fin_ok = (a == v.exp_att - 1) && !v.exp_fail;
      for (int k = 1; k <= FRAME + AW; k++) begin
        @(posedge t_clk); #1;
        cyc = a * 100 + k;
        chk("line", UART_Tx_OUT,
            (k <= FRAME) ? frame_bit(v.data, k) : 1'b1);
        chk("done", tx_done, fin_ok && k == FRAME + AW);
        chk("fail", tx_fail, 0);
        chk("ready", tx_ready, fin_ok && k == FRAME + AW);
        chk("busy", tx_busy, !(fin_ok && k == FRAME + AW));
        if (k == 1) begin
          tx_data = ~v.data;
          if (!v.b2b) tx_valid = 1'b0;
        end
        err_ack = v.emask[a] && k >= v.es && k < v.es + v.el;
      end
    end
    err_ack = 1'b0;
    if (v.exp_fail) begin
      @(posedge t_clk); #1;
      cyc = 999;
      chk("fail_pulse", tx_fail, 1);
      chk("fail_done", tx_done, 0);
      chk("fail_ready", tx_ready, 1);
      chk("fail_busy", tx_busy, 0);
      chk("fail_line", UART_Tx_OUT, 1);
    end
  endtask

  vec_t tbl[7];
  vec_t v;

  initial begin
    tbl[0] = '{8'hA5, 2'b00, 0, 0, 1'b0, 3, 1, 1'b0};
    tbl[1] = '{8'h07, 2'b00, 0, 0, 1'b1, 0, 1, 1'b0};
    tbl[2] = '{8'h00, 2'b00, 0, 0, 1'b0, 2, 1, 1'b0};
    tbl[3] = '{8'h3C, 2'b01, 41, 3, 1'b0, 2, 2, 1'b0};
    tbl[4] = '{8'h3C, 2'b11, 41, 3, 1'b0, 2, 2, 1'b1};
    tbl[5] = '{8'h96, 2'b01, 5, 8, 1'b0, 1, 1, 1'b0};
    tbl[6] = '{8'h96, 2'b01, 37, 2, 1'b0, 1, 1, 1'b0};

    t_rst = 1'b1;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    err_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge t_clk); #1;
      cyc = i;
      chk("rst_line", UART_Tx_OUT, 1);
      chk("rst_ready", tx_ready, 0);
      chk("rst_busy", tx_busy, 0);
      chk("rst_done", tx_done, 0);
      chk("rst_fail", tx_fail, 0);
    end
    t_rst = 1'b0;
    @(posedge t_clk); #1;
    chk("ready_after_rst", tx_ready, 1);

    for (int i = 0; i < 7; i++) begin
      tc = i;
      xfer(tbl[i]);
      idle(tbl[i].gap);
    end

    tc = 100;
    tx_data = 8'h5A;
    tx_valid = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(posedge t_clk); #1;
      cyc = k;
      chk("pre_rst_line", UART_Tx_OUT, frame_bit(8'h5A, k));
      if (k == 1) tx_valid = 1'b0;
    end
    t_rst = 1'b1;
    @(posedge t_clk); #1;
    chk("mid_rst_line", UART_Tx_OUT, 1);
    chk("mid_rst_busy", tx_busy, 0);
    chk("mid_rst_ready", tx_ready, 0);
    chk("mid_rst_done", tx_done, 0);
    chk("mid_rst_fail", tx_fail, 0);
    t_rst = 1'b0;
    @(posedge t_clk); #1;
    chk("post_rst_ready", tx_ready, 1);
    idle(12);
    v = '{8'hC3, 2'b00, 0, 0, 1'b0, 2, 1, 1'b0};
    xfer(v);
    idle(2);

    for (int i = 0; i < 12; i++) begin
      tc = 200 + i;
      v.data  = 8'($urandom_range(0, 255));
      v.emask = 2'($urandom_range(0, 3));
      v.es    = ($urandom_range(0, 1) == 1) ? 41 : 8;
      v.el    = $urandom_range(1, 3);
      v.b2b   = ($urandom_range(0, 1) == 1);
      v.gap   = v.b2b ? 0 : $urandom_range(0, 3);
      v = predict(v);
      xfer(v);
      idle(v.gap);
    end
    tx_valid = 1'b0;
    idle(AW + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
